// File: rtl/dm_arbiter_if.sv
// Bus bundle between the dm_arbiter and its environment.
//   m0_* / m1_* : per-master request side (req, lock, addr, wdata, byteen in;
//                 gnt, rvalid, rdata out of the arbiter).
//   mem_*       : shared data-memory port (addr, wdata, byteen, re out of the
//                 arbiter; rdata into it, valid one cycle after the address).
// Modport slave is the arbiter's view. Modport master is the environment's
// view: the requesting masters plus the memory model.
interface dm_arbiter_if;
    logic        m0_req;
    logic        m0_lock;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_byteen;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_byteen;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_wdata, m0_byteen,
        input  m1_req, m1_lock, m1_addr, m1_wdata, m1_byteen,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_byteen, mem_re
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_wdata, m0_byteen,
        output m1_req, m1_lock, m1_addr, m1_wdata, m1_byteen,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_byteen, mem_re
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory port, with a
// bounded lock so one master can hold the port for back-to-back accesses.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : dm_arbiter_if.slave (master requests, grants, read return, memory port)
// Grants are combinational in the request cycle; read data is routed back to
// the issuing master one cycle later via a registered owner tag.
module dm_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input logic         clk,
    input logic         reset,
    dm_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_LOCK);

    typedef enum logic [1:0] {StArb, StLock0, StLock1} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            rv_valid_q, rv_valid_d;
    logic            rv_idx_q, rv_idx_d;

    logic        hold0, hold1;
    logic        win_valid, win_idx;
    logic        sel_lock;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_byteen;
    logic        mem_re_s;
    state_e      lock_state;

    // A lock holds unless the budget is spent and the other master is waiting.
    assign hold0 = (state_q == StLock0) && bus.m0_req && bus.m0_lock &&
                   !((cnt_q == CntMax) && bus.m1_req);
    assign hold1 = (state_q == StLock1) && bus.m1_req && bus.m1_lock &&
                   !((cnt_q == CntMax) && bus.m0_req);

    always_comb begin
        win_valid = 1'b0;
        win_idx   = 1'b0;
        if (hold0) begin
            win_valid = 1'b1;
            win_idx   = 1'b0;
        end else if (hold1) begin
            win_valid = 1'b1;
            win_idx   = 1'b1;
        end else if (bus.m0_req && bus.m1_req) begin
            // Forced release falls out of this: last_q already names the holder.
            win_valid = 1'b1;
            win_idx   = ~last_q;
        end else if (bus.m0_req) begin
            win_valid = 1'b1;
            win_idx   = 1'b0;
        end else if (bus.m1_req) begin
            win_valid = 1'b1;
            win_idx   = 1'b1;
        end
    end

    always_comb begin
        sel_lock   = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_byteen = '0;
        if (win_valid) begin
            if (win_idx) begin
                sel_lock   = bus.m1_lock;
                sel_addr   = bus.m1_addr;
                sel_wdata  = bus.m1_wdata;
                sel_byteen = bus.m1_byteen;
            end else begin
                sel_lock   = bus.m0_lock;
                sel_addr   = bus.m0_addr;
                sel_wdata  = bus.m0_wdata;
                sel_byteen = bus.m0_byteen;
            end
        end
    end

    assign mem_re_s   = win_valid && (sel_byteen == 4'b0000);
    assign lock_state = win_idx ? StLock1 : StLock0;

    assign bus.m0_gnt     = win_valid && !win_idx;
    assign bus.m1_gnt     = win_valid && win_idx;
    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;
    assign bus.mem_byteen = sel_byteen;
    assign bus.mem_re     = mem_re_s;

    always_comb begin
        state_d    = StArb;
        cnt_d      = '0;
        last_d     = last_q;
        rv_valid_d = 1'b0;
        rv_idx_d   = rv_idx_q;
        if (win_valid) begin
            last_d     = win_idx;
            rv_valid_d = mem_re_s;
            rv_idx_d   = win_idx;
            if (sel_lock) begin
                state_d = lock_state;
                if (state_q == lock_state) begin
                    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
                end else begin
                    cnt_d = CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StArb;
            cnt_q      <= '0;
            last_q     <= 1'b1;  // master 0 wins the first contention
            rv_valid_q <= 1'b0;
            rv_idx_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            rv_valid_q <= rv_valid_d;
            rv_idx_q   <= rv_idx_d;
        end
    end

    assign bus.m0_rvalid = rv_valid_q && !rv_idx_q;
    assign bus.m1_rvalid = rv_valid_q && rv_idx_q;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : 32'h0;

endmodule
